// File: rtl/mult_controller.sv
// mult_controller: sequencer for a shift/add multiplier datapath.
// One start runs LOAD, 2**WIDTH_C CALC steps, then holds DONE.
module mult_controller #(
  parameter int WIDTH_C = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start_valid,
  output logic start_ready,
  input  logic multiplier_lsb,
  input  logic count_check,
  output logic load,
  output logic count_clear,
  output logic add_shift,
  output logic shift,
  output logic busy,
  output logic result_valid,
  input  logic result_ready
);

  if (WIDTH_C < 1) begin : g_width_chk
    $error("mult_controller: WIDTH_C must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   calc_q;

  always_comb begin
    state_d = IDLE;
    unique case (state_q)
      IDLE:    state_d = start_valid  ? LOAD : IDLE;
      LOAD:    state_d = CALC;
      CALC:    state_d = count_check  ? DONE : CALC;
      DONE:    state_d = result_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs are registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      start_ready  <= 1'b1;
      load         <= 1'b0;
      count_clear  <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      calc_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_ready  <= (state_d == IDLE);
      load         <= (state_d == LOAD);
      count_clear  <= (state_d == LOAD);
      busy         <= (state_d == LOAD) || (state_d == CALC);
      result_valid <= (state_d == DONE);
      calc_q       <= (state_d == CALC);
    end
  end

  // Step type follows the live multiplier LSB.
  assign add_shift = calc_q &  multiplier_lsb;
  assign shift     = calc_q & ~multiplier_lsb;

endmodule

// File: tb/tb_mult_controller.sv
// tb_mult_controller: random + directed bench with a cycle model.
// Model tracks phase as a step index; environment models the counter.
module tb_mult_controller;

  localparam int W     = 4;
  localparam int STEPS = 1 << W;

  logic clk;
  logic reset;
  logic start_valid;
  logic start_ready;
  logic multiplier_lsb;
  logic count_check;
  logic load;
  logic count_clear;
  logic add_shift;
  logic shift;
  logic busy;
  logic result_valid;
  logic result_ready;

  mult_controller #(.WIDTH_C(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .start_valid   (start_valid),
    .start_ready   (start_ready),
    .multiplier_lsb(multiplier_lsb),
    .count_check   (count_check),
    .load          (load),
    .count_clear   (count_clear),
    .add_shift     (add_shift),
    .shift         (shift),
    .busy          (busy),
    .result_valid  (result_valid),
    .result_ready  (result_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, got, exp, $time);
    end
  endtask

  // Environment: step counter and lsb source.
  logic [W-1:0] cnt = '0;
  logic         spur = 1'b0;
  logic         spur_en = 1'b0;
  logic         lsb_rand = 1'b0;
  int           mode = 0;

  always @(posedge clk) begin
    if (count_clear)
      cnt <= '0;
    else if (add_shift | shift)
      cnt <= cnt + 1'b1;
  end

  assign count_check = (cnt == W'(STEPS - 1)) | spur;

  always_comb begin
    case (mode)
      1:       multiplier_lsb = ~cnt[0];
      2:       multiplier_lsb = 1'b1;
      3:       multiplier_lsb = 1'b0;
      default: multiplier_lsb = lsb_rand;
    endcase
  end

  // Model: -1 idle, 0 load, 1..STEPS calc step, STEPS+1 done.
  int phase = -1;

  always @(posedge clk or negedge reset) begin
    if (!reset)
      phase <= -1;
    else if (phase == -1)
      phase <= start_valid ? 0 : -1;
    else if (phase <= STEPS)
      phase <= phase + 1;
    else
      phase <= result_ready ? -1 : phase;
  end

  int cyc = 0;
  int n_add = 0;
  int n_shift = 0;
  int n_load = 0;
  int load_cyc[$];

  always @(negedge clk) begin
    logic in_calc;
    in_calc = (phase >= 1) && (phase <= STEPS);
    cyc++;
    if (add_shift) n_add++;
    if (shift) n_shift++;
    if (load) begin
      n_load++;
      load_cyc.push_back(cyc);
    end
    chk("start_ready", start_ready, phase == -1);
    chk("load", load, phase == 0);
    chk("count_clear", count_clear, phase == 0);
    chk("busy", busy, (phase >= 0) && (phase <= STEPS));
    chk("result_valid", result_valid, phase == STEPS + 1);
    chk("add_shift", add_shift, in_calc & multiplier_lsb);
    chk("shift", shift, in_calc & ~multiplier_lsb);
    chk("onehot", $countones({start_ready, busy, result_valid}), 1);
  end

  task automatic step();
    @(posedge clk);
    #1;
    lsb_rand = 1'($urandom);
    spur = spur_en && (phase == -1 || phase == 0 || phase == STEPS + 1);
  endtask

  task automatic clr();
    n_add = 0;
    n_shift = 0;
    n_load = 0;
  endtask

  task automatic do_op(input int m, input int stall,
                       input int e_add, input int e_shift);
    int lat;
    mode = m;
    clr();
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    lat = 0;
    while (!result_valid && lat < 60) begin
      step();
      lat++;
    end
    chk("latency", lat, 17);
    chk("loads", n_load, 1);
    chk("steps", n_add + n_shift, STEPS);
    if (e_add >= 0) chk("adds", n_add, e_add);
    if (e_shift >= 0) chk("shifts", n_shift, e_shift);
    for (int i = 0; i < stall; i++) step();
    chk("stall_valid", result_valid, 1);
    chk("stall_steps", n_add + n_shift, STEPS);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk("back_idle", start_ready, 1);
  endtask

  initial begin
    int k;
    start_valid  = 1'b0;
    result_ready = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    step();
    step();
    chk("rst_ready", start_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_load", load, 0);
    reset = 1'b1;
    step();

    do_op(1, 0, 8, 8);
    do_op(0, 10, -1, -1);
    do_op(2, 0, 16, 0);
    do_op(3, 0, 0, 16);

    // Start held high: one idle cycle between ops.
    mode = 1;
    load_cyc.delete();
    start_valid  = 1'b1;
    result_ready = 1'b1;
    for (int i = 0; i < 45; i++) step();
    start_valid = 1'b0;
    k = 0;
    while (!start_ready && k < 40) begin
      step();
      k++;
    end
    result_ready = 1'b0;
    chk("b2b_loads", load_cyc.size() >= 2, 1);
    if (load_cyc.size() >= 2)
      chk("b2b_period", load_cyc[1] - load_cyc[0], 19);

    // Reset in the 7th CALC step.
    mode = 0;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    k = 0;
    while (phase != 7 && k < 30) begin
      step();
      k++;
    end
    chk("reach_step7", phase, 7);
    reset = 1'b0;
    #1;
    chk("async_ready", start_ready, 1);
    chk("async_add", add_shift, 0);
    chk("async_shift", shift, 0);
    chk("async_busy", busy, 0);
    step();
    step();
    reset = 1'b1;
    step();
    step();
    chk("no_stale_valid", result_valid, 0);
    do_op(0, 0, -1, -1);

    // Spurious count_check in IDLE, LOAD and DONE.
    spur_en = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("spur_idle", start_ready, 1);
    do_op(1, 2, 8, 8);
    spur_en = 1'b0;

    // Random traffic with occasional reset pulses.
    for (int i = 0; i < 1500; i++) begin
      start_valid  = ($urandom_range(0, 2) == 0);
      result_ready = ($urandom_range(0, 2) == 0);
      spur_en      = 1'($urandom);
      if ($urandom_range(0, 19) == 0) mode = $urandom_range(0, 3);
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b0;
        step();
        reset = 1'b1;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
